wb_ddr_arbiter: RTL and testbench
=================================

WB_DDR_ARBITER -- requirements
Module: wb_ddr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of Wishbone initiators sharing one DDR/HyperRAM port.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width; SEL width is DATA_W/8.
REQ-004 SHALL have parameter MAX_OUT, default 8: maximum outstanding target transactions.
REQ-005 SHALL have one clock and one reset: Clk in 1, the single clock; Reset in 1, asynchronous, active-low.
REQ-006 SHALL have ICyc, IStb and IWe, in, NUM_REQ each: per-requester cycle, strobe and write-enable.
REQ-007 SHALL have IAdr in NUM_REQ*ADDR_W, IDatW in NUM_REQ*DATA_W and ISel in NUM_REQ*DATA_W/8: per-requester address, write data and byte selects.
REQ-008 SHALL have IAck, IErr and IStall, out, NUM_REQ each: per-requester responses.
REQ-009 SHALL have IDatR out DATA_W: read data, broadcast to all requesters.
REQ-010 SHALL have TCyc, TStb and TWe out 1, TAdr out ADDR_W, TDatW out DATA_W and TSel out DATA_W/8: target-side request.
REQ-011 SHALL have TAck, TErr and TStall in 1 and TDatR in DATA_W: target-side response.
REQ-012 SHALL have Grant out NUM_REQ: one-hot current owner, all-zero when idle.

Function
REQ-013 SHALL implement Wishbone Classic Pipelined on both sides.
REQ-014 SHALL have two states, IDLE and OWNED.
REQ-015 IDLE: if any ICyc is high, SHALL pick a winner by round-robin, starting at the index after the last owner; on the next edge it SHALL register Grant and enter OWNED.
REQ-016 Latency: when ICyc rises at edge N with the arbiter idle, TCyc SHALL be high after edge N+1.
REQ-017 OWNED: TCyc, TStb, TWe, TAdr, TDatW and TSel SHALL pass combinationally from the owner; TStb SHALL be gated to 0 when the limit is reached.
REQ-018 The owner's IStall SHALL equal TStall OR (outstanding==MAX_OUT); every non-owner's IStall SHALL be 1.
REQ-019 IAck and IErr SHALL be driven only to the owner, from TAck and TErr; non-owners SHALL see 0.
REQ-020 Outstanding counter, width clog2(MAX_OUT+1):
- +1 on TStb&!TStall;
- -1 on TAck|TErr;
- both in the same cycle: unchanged;
- SHALL never exceed MAX_OUT or wrap below 0.
REQ-021 OWNED->IDLE SHALL occur on the edge where the owner's ICyc is low; the last-owner pointer SHALL update then. There is one dead cycle before the next grant.
REQ-022 If the owner drops ICyc with outstanding>0:
- TCyc SHALL drop with it (abort);
- the counter SHALL clear;
- TAck/TErr during the abort SHALL be ignored.
REQ-023 Requests arriving while OWNED SHALL wait; the owner SHALL keep the bus for as long as its ICyc stays high (no preemption).
REQ-024 With a single requester, back-to-back cycles SHALL be re-granted to it after the dead cycle.
REQ-025 Pointer wrap: after index NUM_REQ-1, the search SHALL continue at index 0.

Reset
REQ-026 While Reset is low, the following SHALL hold:
- state IDLE, Grant 0, counter 0, last-owner pointer NUM_REQ-1 (index 0 wins first);
- TCyc/TStb/TWe 0, TAdr/TDatW/TSel 0;
- IAck/IErr 0, IStall all 1, IDatR 0.
REQ-027 Reset asserted mid-transaction SHALL abort immediately; responses after release SHALL be ignored until a new grant.

Structure
REQ-028 Package retro_bus_pkg SHALL hold the arbiter state enum and the default width and depth constants.
REQ-029 Sub-module rr_picker SHALL be combinational. Inputs: request vector and last-owner index. Outputs: one-hot winner and a valid flag.
REQ-030 The counter and FSM SHALL live in wb_ddr_arbiter.

Verification
REQ-031 Requesters 0 and 2 raise ICyc in the same cycle from reset -> Grant=0001; after req0 drops, the dead cycle follows, then Grant=0100.
REQ-032 All four hold ICyc continuously, each releasing after 1 transfer -> grant order 0,1,2,3,0.
REQ-033 Owner issues 10 strobes with TStall=0 and TAck withheld (MAX_OUT=8) -> exactly 8 TStb accepted, IStall=1 on the 9th; one TAck -> the 9th is accepted.
REQ-034 Strobe accept and TAck in the same cycle at outstanding=3 -> counter stays 3.
REQ-035 Owner drops ICyc with 2 outstanding -> TCyc=0 the same cycle; a later TAck produces no IAck; counter=0.
REQ-036 Reset driven low mid-burst with Grant=0010 -> all outputs at reset values asynchronously; after release, req3 alone requesting -> Grant=1000 two edges later.

Source files
------------

// File: rtl/retro_bus_pkg.sv
// ---------------------------------------------------------------------------
// retro_bus_pkg
// Shared types and default sizes for the Wishbone -> DDR/HyperRAM arbiter.
//   arb_state_e : arbiter FSM state (idle / bus owned by one initiator)
//   DEF_*       : default requester count, address/data widths, outstanding depth
// ---------------------------------------------------------------------------
package retro_bus_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_MAX_OUT = 8;

endpackage

// File: rtl/wb_ddr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_ddr_arbiter_if
// Wishbone Classic Pipelined bundle carrying N parallel initiators.
// The initiator side of the arbiter uses N = NUM_REQ, the target side N = 1.
//   master : drives Cyc/Stb/We/Adr/DatW/Sel, receives Ack/Err/Stall/DatR
//   slave  : the reverse
// DatR is a single broadcast bus shared by all N lanes.
// ---------------------------------------------------------------------------
interface wb_ddr_arbiter_if
   import retro_bus_pkg::*;
#(
   parameter int N      = 1,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [N-1:0]                 Cyc;
   logic [N-1:0]                 Stb;
   logic [N-1:0]                 We;
   logic [N-1:0][ADDR_W-1:0]     Adr;
   logic [N-1:0][DATA_W-1:0]     DatW;
   logic [N-1:0][DATA_W/8-1:0]   Sel;
   logic [N-1:0]                 Ack;
   logic [N-1:0]                 Err;
   logic [N-1:0]                 Stall;
   logic [DATA_W-1:0]            DatR;

   modport master (
      output Cyc, Stb, We, Adr, DatW, Sel,
      input  Ack, Err, Stall, DatR
   );

   modport slave (
      input  Cyc, Stb, We, Adr, DatW, Sel,
      output Ack, Err, Stall, DatR
   );

endinterface

// File: rtl/wb_ddr_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector.
//   req_i  : request vector (one bit per initiator)
//   last_i : index of the previous owner; search starts at last_i+1 and wraps
//   win_o  : one-hot winner (zero when nothing requests)
//   vld_o  : a winner exists
// ---------------------------------------------------------------------------
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] win_o,
   output logic               vld_o
);

   always_comb begin
      int               s;
      logic [IDX_W-1:0] idx;
      s     = 0;
      idx   = '0;
      win_o = '0;
      vld_o = 1'b0;
      // Offset NUM_REQ lands back on last_i itself, so a lone requester is
      // re-granted after its own release.
      for (int o = 1; o <= NUM_REQ; o++) begin
         s = int'(last_i) + o;
         if (s >= NUM_REQ) s = s - NUM_REQ;
         idx = IDX_W'(s);
         if (!vld_o && req_i[idx]) begin
            win_o[idx] = 1'b1;
            vld_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_ddr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ddr_arbiter
// Shares one pipelined Wishbone DDR/HyperRAM port among NUM_REQ initiators.
//   Clk, Reset : clock, asynchronous active-low reset
//   ini        : initiator-side bundle (slave modport, NUM_REQ lanes)
//   tgt        : target-side bundle (master modport, one lane)
//   Grant      : registered one-hot owner, zero while idle
// The owner's request passes straight through; strobes are held off once
// MAX_OUT transactions are in flight. Dropping Cyc ends ownership and aborts
// anything still outstanding.
// ---------------------------------------------------------------------------
module wb_ddr_arbiter
   import retro_bus_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MAX_OUT = DEF_MAX_OUT
) (
   input  logic                 Clk,
   input  logic                 Reset,
   wb_ddr_arbiter_if.slave      ini,
   wb_ddr_arbiter_if.master     tgt,
   output logic [NUM_REQ-1:0]   Grant
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   arb_state_e          state_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [IDX_W-1:0]    last_q;
   logic [CNT_W-1:0]    out_q, out_d;

   logic [NUM_REQ-1:0]  pick_win;
   logic                pick_vld;

   logic                own_cyc, own_stb, own_we;
   logic [ADDR_W-1:0]   own_adr;
   logic [DATA_W-1:0]   own_datw;
   logic [DATA_W/8-1:0] own_sel;
   logic [IDX_W-1:0]    owner_idx;
   logic                at_limit, acc, rsp;

   rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req_i  (ini.Cyc),
      .last_i (last_q),
      .win_o  (pick_win),
      .vld_o  (pick_vld)
   );

   // Owner mux: grant_q is zero while idle, so everything reads as zero then.
   always_comb begin
      own_cyc   = 1'b0;
      own_stb   = 1'b0;
      own_we    = 1'b0;
      own_adr   = '0;
      own_datw  = '0;
      own_sel   = '0;
      owner_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            own_cyc   = ini.Cyc[i];
            own_stb   = ini.Stb[i];
            own_we    = ini.We[i];
            own_adr   = ini.Adr[i];
            own_datw  = ini.DatW[i];
            own_sel   = ini.Sel[i];
            owner_idx = IDX_W'(i);
         end
      end
   end

   assign at_limit = (out_q == CNT_W'(MAX_OUT));

   // Target request follows the owner; Cyc drops with the owner's Cyc so an
   // abandoned cycle is aborted on the target in the same clock.
   assign tgt.Cyc[0]  = own_cyc;
   assign tgt.Stb[0]  = own_cyc & own_stb & ~at_limit;
   assign tgt.We[0]   = own_we;
   assign tgt.Adr[0]  = own_adr;
   assign tgt.DatW[0] = own_datw;
   assign tgt.Sel[0]  = own_sel;

   // Responses only reach an owner that still holds Cyc; anything arriving
   // during an abort or while idle is dropped.
   assign ini.Stall = ~grant_q | (grant_q & {NUM_REQ{tgt.Stall[0] | at_limit}});
   assign ini.Ack   = grant_q & {NUM_REQ{own_cyc & tgt.Ack[0]}};
   assign ini.Err   = grant_q & {NUM_REQ{own_cyc & tgt.Err[0]}};
   assign ini.DatR  = own_cyc ? tgt.DatR : '0;

   assign Grant = grant_q;

   assign acc = tgt.Stb[0] & ~tgt.Stall[0];
   assign rsp = own_cyc & (tgt.Ack[0] | tgt.Err[0]);

   // Accept can only happen below the limit; a response with nothing in
   // flight is ignored so the count never goes negative.
   always_comb begin
      out_d = out_q;
      if (!own_cyc)
         out_d = '0;
      else if (acc && !rsp)
         out_d = out_q + CNT_W'(1);
      else if (rsp && !acc && (out_q != '0))
         out_d = out_q - CNT_W'(1);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         out_q   <= '0;
      end else begin
         out_q <= out_d;
         case (state_q)
            ST_IDLE: begin
               if (pick_vld) begin
                  grant_q <= pick_win;
                  state_q <= ST_OWNED;
               end
            end
            ST_OWNED: begin
               if (!own_cyc) begin
                  grant_q <= '0;
                  last_q  <= owner_idx;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
module tb_wb_ddr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 8;

   logic         Clk   = 1'b0;
   logic         Reset = 1'b0;
   logic [N-1:0] Grant;

   wb_ddr_arbiter_if #(.N(N), .ADDR_W(AW), .DATA_W(DW)) ini ();
   wb_ddr_arbiter_if #(.N(1), .ADDR_W(AW), .DATA_W(DW)) tgt ();

   wb_ddr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .ini   (ini),
      .tgt   (tgt),
      .Grant (Grant)
   );

   always #5 Clk = ~Clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clr_in();
      ini.Cyc   = '0;
      ini.Stb   = '0;
      ini.We    = '0;
      ini.Adr   = '0;
      ini.DatW  = '0;
      ini.Sel   = '0;
      tgt.Ack   = '0;
      tgt.Err   = '0;
      tgt.Stall = '0;
      tgt.DatR  = '0;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      clr_in();
      @(posedge Clk);
      @(posedge Clk);
      #3 Reset = 1'b1;
   endtask

   task automatic chk_rst(input string p);
      chk({p, "_grant"}, 64'(Grant), 64'(0));
      chk({p, "_tcyc"},  64'(tgt.Cyc), 64'(0));
      chk({p, "_tstb"},  64'(tgt.Stb), 64'(0));
      chk({p, "_twe"},   64'(tgt.We), 64'(0));
      chk({p, "_tadr"},  64'(tgt.Adr[0]), 64'(0));
      chk({p, "_tdatw"}, 64'(tgt.DatW[0]), 64'(0));
      chk({p, "_tsel"},  64'(tgt.Sel[0]), 64'(0));
      chk({p, "_iack"},  64'(ini.Ack), 64'(0));
      chk({p, "_ierr"},  64'(ini.Err), 64'(0));
      chk({p, "_istall"}, 64'(ini.Stall), 64'(4'b1111));
      chk({p, "_idatr"}, 64'(ini.DatR), 64'(0));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         rst;
      logic [3:0] cyc;
      logic [3:0] stb;
      bit         ack;
      logic [3:0] grant;
      bit         tcyc;
      bit         tstb;
      logic [3:0] iack;
   } vec_t;

   function automatic vec_t mk(bit r, logic [3:0] c, logic [3:0] s, bit a,
                               logic [3:0] g, bit tc, bit ts, logic [3:0] ia);
      vec_t v;
      v.rst = r; v.cyc = c; v.stb = s; v.ack = a;
      v.grant = g; v.tcyc = tc; v.tstb = ts; v.iack = ia;
      return v;
   endfunction

   vec_t tbl[$];

   // ---------------- reference model ----------------
   bit       m_busy;
   logic [1:0] m_own;
   logic [1:0] m_last;
   int       m_cnt;

   task automatic model_reset();
      m_busy = 1'b0;
      m_own  = 2'd0;
      m_last = 2'(N - 1);
      m_cnt  = 0;
   endtask

   task automatic model_check_and_advance();
      logic [3:0]  e_grant, e_stall, e_ack, e_err;
      logic        oc, e_tstb, e_we, accepted, resp;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_datw, e_datr;
      logic [3:0]  e_sel;
      logic [1:0]  j;
      bit          found;

      oc      = m_busy && ini.Cyc[m_own];
      e_grant = m_busy ? (4'b0001 << m_own) : 4'b0000;
      e_tstb  = oc && ini.Stb[m_own] && (m_cnt < MO);
      e_we    = m_busy && ini.We[m_own];
      e_adr   = m_busy ? ini.Adr[m_own]  : '0;
      e_datw  = m_busy ? ini.DatW[m_own] : '0;
      e_sel   = m_busy ? ini.Sel[m_own]  : '0;
      e_stall = 4'b1111;
      if (m_busy) e_stall[m_own] = tgt.Stall[0] || (m_cnt == MO);
      e_ack   = (oc && tgt.Ack[0]) ? (4'b0001 << m_own) : 4'b0000;
      e_err   = (oc && tgt.Err[0]) ? (4'b0001 << m_own) : 4'b0000;
      e_datr  = oc ? tgt.DatR : '0;

      chk("rnd_grant",  64'(Grant), 64'(e_grant));
      chk("rnd_tcyc",   64'(tgt.Cyc), 64'(oc));
      chk("rnd_tstb",   64'(tgt.Stb), 64'(e_tstb));
      chk("rnd_twe",    64'(tgt.We), 64'(e_we));
      chk("rnd_tadr",   64'(tgt.Adr[0]), 64'(e_adr));
      chk("rnd_tdatw",  64'(tgt.DatW[0]), 64'(e_datw));
      chk("rnd_tsel",   64'(tgt.Sel[0]), 64'(e_sel));
      chk("rnd_istall", 64'(ini.Stall), 64'(e_stall));
      chk("rnd_iack",   64'(ini.Ack), 64'(e_ack));
      chk("rnd_ierr",   64'(ini.Err), 64'(e_err));
      chk("rnd_idatr",  64'(ini.DatR), 64'(e_datr));

      if (!m_busy) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            j = m_last + 2'(k);
            if (!found && ini.Cyc[j]) begin
               found  = 1'b1;
               m_busy = 1'b1;
               m_own  = j;
               m_cnt  = 0;
            end
         end
      end else if (!ini.Cyc[m_own]) begin
         m_last = m_own;
         m_busy = 1'b0;
         m_cnt  = 0;
      end else begin
         accepted = e_tstb && !tgt.Stall[0];
         resp     = tgt.Ack[0] || tgt.Err[0];
         if (accepted && !resp)      m_cnt = m_cnt + 1;
         else if (resp && !accepted && m_cnt > 0) m_cnt = m_cnt - 1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      logic [3:0] rc;

      // Reset state with busy inputs
      Reset     = 1'b0;
      ini.Cyc   = 4'b1111;
      ini.Stb   = 4'b1111;
      ini.We    = 4'b1111;
      for (int i = 0; i < N; i++) begin
         ini.Adr[i]  = 32'hA000_0000 + 32'(i);
         ini.DatW[i] = 32'h5555_0000 + 32'(i);
         ini.Sel[i]  = 4'hF;
      end
      tgt.Ack   = 1'b1;
      tgt.Err   = 1'b1;
      tgt.Stall = 1'b0;
      tgt.DatR  = 32'hCAFE_F00D;
      #3;
      chk_rst("reset");

      // Table: two-requester handoff, then four-way rotation
      tbl.push_back(mk(1, 4'b0101, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b0101, 4'b0001, 0, 4'b0001, 1, 1, 4'b0000));
      tbl.push_back(mk(0, 4'b0101, 4'b0000, 1, 4'b0001, 1, 0, 4'b0001));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0001, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0100, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 1, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 1, 0, 4'b0001));
      tbl.push_back(mk(0, 4'b1110, 4'b0000, 0, 4'b0001, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0010, 1, 0, 4'b0010));
      tbl.push_back(mk(0, 4'b1101, 4'b0000, 0, 4'b0010, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 1, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0100, 1, 0, 4'b0100));
      tbl.push_back(mk(0, 4'b1011, 4'b0000, 0, 4'b0100, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b1000, 1, 1, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 1, 0, 4'b1000));
      tbl.push_back(mk(0, 4'b0111, 4'b0000, 0, 4'b1000, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0001, 1, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000));

      for (int r = 0; r < tbl.size(); r++) begin
         if (tbl[r].rst) do_reset();
         ini.Cyc = tbl[r].cyc;
         ini.Stb = tbl[r].stb;
         tgt.Ack = tbl[r].ack;
         #1;
         chk($sformatf("tbl%0d_grant", r), 64'(Grant), 64'(tbl[r].grant));
         chk($sformatf("tbl%0d_tcyc", r),  64'(tgt.Cyc), 64'(tbl[r].tcyc));
         chk($sformatf("tbl%0d_tstb", r),  64'(tgt.Stb), 64'(tbl[r].tstb));
         chk($sformatf("tbl%0d_iack", r),  64'(ini.Ack), 64'(tbl[r].iack));
         step();
      end

      // Outstanding limit: 8 accepted, 9th stalled, one ack frees a slot
      do_reset();
      ini.Cyc = 4'b0001;
      step();
      ini.Stb = 4'b0001;
      acc = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (tgt.Stb[0] && !tgt.Stall[0]) acc++;
         if (k == 8) chk("limit_istall_9th", 64'(ini.Stall[0]), 64'(1));
         step();
      end
      chk("limit_accepted", 64'(acc), 64'(8));
      tgt.Ack = 1'b1;
      #1;
      chk("limit_tstb_gated", 64'(tgt.Stb), 64'(0));
      chk("limit_iack", 64'(ini.Ack), 64'(4'b0001));
      step();
      tgt.Ack = 1'b0;
      #1;
      chk("limit_9th_accepted", 64'(tgt.Stb & ~tgt.Stall), 64'(1));
      chk("limit_istall_free", 64'(ini.Stall), 64'(4'b1110));
      step();

      // Simultaneous accept and ack at 3 outstanding keeps the count at 3
      do_reset();
      ini.Cyc = 4'b0001;
      step();
      ini.Stb = 4'b0001;
      repeat (3) step();
      tgt.Ack = 1'b1;
      #1;
      chk("same_cycle_accept", 64'(tgt.Stb & ~tgt.Stall), 64'(1));
      step();
      tgt.Ack = 1'b0;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (tgt.Stb[0] && !tgt.Stall[0]) acc++;
         step();
      end
      chk("same_cycle_count_held", 64'(acc), 64'(5));

      // Abort with 2 outstanding
      do_reset();
      ini.Cyc = 4'b0001;
      step();
      ini.Stb = 4'b0001;
      step();
      step();
      ini.Stb = 4'b0000;
      ini.Cyc = 4'b0000;
      tgt.Ack = 1'b1;
      #1;
      chk("abort_tcyc", 64'(tgt.Cyc), 64'(0));
      chk("abort_iack", 64'(ini.Ack), 64'(0));
      step();
      #1;
      chk("abort_late_iack", 64'(ini.Ack), 64'(0));
      chk("abort_idle_grant", 64'(Grant), 64'(0));
      step();
      tgt.Ack = 1'b0;
      ini.Cyc = 4'b0001;
      step();
      ini.Stb = 4'b0001;
      acc = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (tgt.Stb[0] && !tgt.Stall[0]) acc++;
         step();
      end
      chk("abort_counter_cleared", 64'(acc), 64'(8));

      // Asynchronous reset mid-burst while requester 1 owns the bus
      do_reset();
      ini.Cyc = 4'b0010;
      step();
      ini.Stb     = 4'b0010;
      ini.We      = 4'b0010;
      ini.Adr[1]  = 32'h1234_5678;
      ini.DatW[1] = 32'h8765_4321;
      ini.Sel[1]  = 4'hF;
      tgt.Ack     = 1'b1;
      tgt.DatR    = 32'hDEAD_BEEF;
      #1;
      chk("midrst_grant_before", 64'(Grant), 64'(4'b0010));
      chk("midrst_tadr_before", 64'(tgt.Adr[0]), 64'(32'h1234_5678));
      #2 Reset = 1'b0;
      #1;
      chk_rst("midrst");
      clr_in();
      tgt.Ack  = 1'b1;
      tgt.DatR = 32'hDEAD_BEEF;
      @(posedge Clk);
      #2 Reset = 1'b1;
      #1;
      chk("postrst_iack", 64'(ini.Ack), 64'(0));
      step();
      chk("postrst_grant_e1", 64'(Grant), 64'(0));
      chk("postrst_iack_e1", 64'(ini.Ack), 64'(0));
      ini.Cyc = 4'b1000;
      step();
      chk("postrst_grant_e2", 64'(Grant), 64'(4'b1000));
      clr_in();
      step();

      // Randomized traffic against the model
      do_reset();
      model_reset();
      rc = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 15) == 0) rc[i] = ~rc[i];
         ini.Cyc = rc;
         ini.Stb = 4'($urandom() | $urandom());
         ini.We  = 4'($urandom());
         for (int i = 0; i < N; i++) begin
            ini.Adr[i]  = $urandom();
            ini.DatW[i] = $urandom();
            ini.Sel[i]  = 4'($urandom());
         end
         tgt.Stall = ($urandom_range(0, 3) == 0);
         tgt.Ack   = ($urandom_range(0, 5) == 0);
         tgt.Err   = ($urandom_range(0, 23) == 0);
         tgt.DatR  = $urandom();
         #1;
         model_check_and_advance();
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", n_err + 1);
      $fatal(1);
   end

endmodule
